j1_irq_ctrl: RTL
================

Name: j1_irq_ctrl

Overview:
Interrupt controller for the J1 core's single `interrupt_request` line. It sits on the J1 IO bus (`io_rd`/`io_wr`/`io_addr`/`io_dout`/`io_din`) and collects up to NSRC peripheral interrupt sources. It keeps per-source pending/enable/mode state, chooses the highest-priority request, and sequences one request → claim → end-of-interrupt (EOI) cycle at a time. The core's own enable (`pc[0]`) still gates entry; this block only decides when to raise the request.

Parameters:
- NSRC, 8, number of interrupt sources (1..15). Source 0 has highest priority.
- BASE, 16'h0040, IO base address; registers sit at BASE+0, +2, +4, +6, +8 (byte addresses, exact 16-bit match).

Ports:
- clk  input  1  system clock, shared with the J1 core
- reset  input  1  synchronous, active-high reset
- io_rd  input  1  J1 IO read strobe, one cycle per read instruction
- io_wr  input  1  J1 IO write strobe, one cycle per write instruction
- io_addr  input  16  J1 IO address
- io_dout  input  16  J1 write data
- io_din  output  16  read data: combinational from io_addr; 16'h0000 when the address does not hit this block (OR-merged at top level)
- irq_src  input  NSRC  raw asynchronous interrupt sources
- interrupt_request  output  1  to J1 `interrupt_request`

Behaviour:
- Reset (synchronous, active-high, wins over every other event): pending=0, enable=0, mode=0 (all level), synchronizer flops=0, FSM=IDLE, interrupt_request=0, in-service id=0.
- Source path: 2-flop synchronizer per bit, then a previous-value flop for rising-edge detection. Source to pending: 3 clocks (edge mode).
- mode[i]=1 (edge): pending[i] sets on a synchronized rising edge. It clears on a W1C write or on a claim of source i. If set and clear happen in the same cycle, set wins.
- mode[i]=0 (level): pending[i] equals the synchronized level every cycle. W1C and claim have no effect.
- Eligible vector: `elig = pending & enable`. Winner = lowest set index of `elig`.
- Register map (io_din must be valid in the same cycle as io_rd; zero-extend unused bits):
  - BASE+0 PENDING: read returns pending. A write clears every edge-mode bit where io_dout is 1.
  - BASE+2 ENABLE: read/write.
  - BASE+4 CLAIM: read returns {elig!=0, 11'b0, winner[3:0]}, or 16'h0000 when nothing is eligible. A read with io_rd only in state REQ and elig!=0 is a claim: it latches the winner as in-service id, clears that pending bit (edge mode), and moves to SERVICE. A claim read in any other state returns the same value but has no side effect. Writes are ignored.
  - BASE+6 MODE: read/write. A bit that changes from level to edge keeps its current pending value.
  - BASE+8 EOI: any write while in SERVICE moves to IDLE; any write in another state is ignored. Read returns {SERVICE, 11'b0, in-service id}.
- FSM:
  - IDLE → REQ when elig!=0 (evaluated on registered state, so the request rises 1 cycle after elig becomes non-zero).
  - REQ: interrupt_request=1 (registered output). REQ → SERVICE on a claim. REQ → IDLE if elig becomes 0 without a claim (masked, W1C, or level dropped); the request falls on the next clock.
  - SERVICE: interrupt_request=0. New pending bits accumulate. SERVICE → IDLE on an EOI write. From IDLE the request re-rises after 1 cycle if elig!=0.
- No nesting. At most one in-service source at a time.
- Simultaneous io_rd and io_wr: handle both independently. If EOI and claim occur in the same cycle, EOI is processed first (FSM moves to IDLE, the claim is ignored).
- Unused address bits / NSRC < 16: upper bits read 0; writes to them are ignored.

Test Plan:
- Reset then idle: irq_src=0 for 10 cycles → interrupt_request=0, all register reads 16'h0000.
- Edge-mode request: write MODE=16'h0001 and ENABLE=16'h0001, pulse irq_src[0] for 1 cycle → PENDING reads 16'h0001 3 cycles later; interrupt_request=1 one cycle after that. CLAIM read returns 16'h8000, request drops next cycle, PENDING=0. EOI write → IDLE with request held at 0.
- Priority: edge sources 2 and 5 enabled, both pulsed in the same cycle → claim returns 16'h8002. After EOI the request re-rises after 1 cycle and the next claim returns 16'h8005.
- Level mode: enable source 3 in level mode, hold irq_src[3]=1 → claim returns 16'h8003. W1C write 16'h0008 leaves PENDING=16'h0008. After irq_src[3] drops and EOI is written, the request stays 0.
- Mask while requesting: in REQ, write ENABLE=0 → interrupt_request=0 next cycle, FSM=IDLE. Re-enable → request returns after 1 cycle.
- Reset mid-service: assert reset while in SERVICE with PENDING non-zero → next cycle all state is cleared, interrupt_request=0, EOI read returns 16'h0000.

Source files
------------

// File: rtl/j1_irq_ctrl_if.sv
// J1 IO bus bundle: read/write strobes, address, write data and read data.
// The J1 core is the master; peripherals such as the interrupt controller
// are slaves that return combinational read data on io_din.
interface j1_irq_ctrl_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (
        output io_rd,
        output io_wr,
        output io_addr,
        output io_dout,
        input  io_din
    );

    modport slave (
        input  io_rd,
        input  io_wr,
        input  io_addr,
        input  io_dout,
        output io_din
    );
endinterface

// File: rtl/j1_irq_ctrl.sv
// Interrupt controller for the J1 core.
// Collects NSRC asynchronous sources, keeps pending/enable/mode state,
// picks the lowest-numbered eligible source and runs one
// request -> claim -> EOI sequence at a time on interrupt_request.
// io_din is combinational from io_addr and reads 0 outside the register
// window so it can be OR-merged with other peripherals.
module j1_irq_ctrl #(
    parameter int          NSRC = 8,
    parameter logic [15:0] BASE = 16'h0040
) (
    input  logic              clk,
    input  logic              reset,
    j1_irq_ctrl_if.slave      io,
    input  logic [NSRC-1:0]   irq_src,
    output logic              interrupt_request
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [15:0] ADDR_PEND  = BASE;
    localparam logic [15:0] ADDR_EN    = BASE + 16'd2;
    localparam logic [15:0] ADDR_CLAIM = BASE + 16'd4;
    localparam logic [15:0] ADDR_MODE  = BASE + 16'd6;
    localparam logic [15:0] ADDR_EOI   = BASE + 16'd8;

    // Lowest set index wins; scanning downwards lets lower indices overwrite.
    function automatic logic [3:0] pick_winner(input logic [NSRC-1:0] v);
        logic [3:0] w;
        w = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            w = v[i] ? 4'(i) : w;
        end
        return w;
    endfunction

    // Registers
    state_t            state_q, state_d;
    logic              irq_q, irq_d;
    logic [NSRC-1:0]   sync1_q, sync1_d;
    logic [NSRC-1:0]   sync2_q, sync2_d;
    logic [NSRC-1:0]   prev_q, prev_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   enable_q, enable_d;
    logic [NSRC-1:0]   mode_q, mode_d;
    logic [3:0]        insvc_q, insvc_d;

    // Combinational helpers
    logic [NSRC-1:0]   rise_s;
    logic [NSRC-1:0]   elig_s;
    logic              elig_any_s;
    logic [3:0]        winner_s;
    logic              wr_pend_s;
    logic              wr_en_s;
    logic              wr_mode_s;
    logic              eoi_s;
    logic              claim_s;
    logic [NSRC-1:0]   clr_s;
    logic [15:0]       pend_ext_s;
    logic [15:0]       en_ext_s;
    logic [15:0]       mode_ext_s;
    logic [15:0]       din_s;

    // Upper write-data bits have no register behind them when NSRC < 16.
    if (NSRC < 16) begin : g_unused_dout
        logic unused_dout_s;
        assign unused_dout_s = ^io.io_dout[15:NSRC];
    end

    assign rise_s     = sync2_q & ~prev_q;
    assign elig_s     = pending_q & enable_q;
    assign elig_any_s = |elig_s;
    assign winner_s   = pick_winner(elig_s);

    assign wr_pend_s  = io.io_wr && (io.io_addr == ADDR_PEND);
    assign wr_en_s    = io.io_wr && (io.io_addr == ADDR_EN);
    assign wr_mode_s  = io.io_wr && (io.io_addr == ADDR_MODE);
    // EOI only counts while a source is in service.
    assign eoi_s      = io.io_wr && (io.io_addr == ADDR_EOI) && (state_q == ST_SERVICE);
    // A claim needs a live request and something eligible; EOI takes precedence.
    assign claim_s    = io.io_rd && (io.io_addr == ADDR_CLAIM) && (state_q == ST_REQ)
                        && elig_any_s && !eoi_s;

    assign interrupt_request = irq_q;
    assign io.io_din         = din_s;

    // FSM state and registered request output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    // FSM next state; the request flop mirrors "next state is REQ".
    always_comb begin
        state_d = state_q;
        irq_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_any_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (claim_s) begin
                    state_d = ST_SERVICE;
                end else if (!elig_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d = (state_d == ST_REQ);
    end

    // Source synchronizers, edge history and software-visible state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= {NSRC{1'b0}};
            sync2_q   <= {NSRC{1'b0}};
            prev_q    <= {NSRC{1'b0}};
            pending_q <= {NSRC{1'b0}};
            enable_q  <= {NSRC{1'b0}};
            mode_q    <= {NSRC{1'b0}};
            insvc_q   <= 4'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            insvc_q   <= insvc_d;
        end
    end

    // Next values: synchronizer chain, pending set/clear, register writes.
    always_comb begin
        sync1_d   = irq_src;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        clr_s     = {NSRC{1'b0}};
        pending_d = pending_q;

        for (int i = 0; i < NSRC; i++) begin
            clr_s[i] = (wr_pend_s && io.io_dout[i]) || (claim_s && (winner_s == 4'(i)));
            if (mode_q[i]) begin
                // Edge mode: a new edge beats a simultaneous clear.
                pending_d[i] = rise_s[i] | (pending_q[i] & ~clr_s[i]);
            end else begin
                // Level mode: pending tracks the synchronized line.
                pending_d[i] = sync2_q[i];
            end
        end

        if (wr_en_s) begin
            enable_d = io.io_dout[NSRC-1:0];
        end else begin
            enable_d = enable_q;
        end

        if (wr_mode_s) begin
            mode_d = io.io_dout[NSRC-1:0];
        end else begin
            mode_d = mode_q;
        end

        if (claim_s) begin
            insvc_d = winner_s;
        end else begin
            insvc_d = insvc_q;
        end
    end

    // Read-data mux, zero outside the register window.
    always_comb begin
        pend_ext_s             = 16'h0000;
        en_ext_s               = 16'h0000;
        mode_ext_s             = 16'h0000;
        pend_ext_s[NSRC-1:0]   = pending_q;
        en_ext_s[NSRC-1:0]     = enable_q;
        mode_ext_s[NSRC-1:0]   = mode_q;
        din_s                  = 16'h0000;

        if (io.io_addr == ADDR_PEND) begin
            din_s = pend_ext_s;
        end else if (io.io_addr == ADDR_EN) begin
            din_s = en_ext_s;
        end else if (io.io_addr == ADDR_CLAIM) begin
            if (elig_any_s) begin
                din_s = {1'b1, 11'b0, winner_s};
            end else begin
                din_s = 16'h0000;
            end
        end else if (io.io_addr == ADDR_MODE) begin
            din_s = mode_ext_s;
        end else if (io.io_addr == ADDR_EOI) begin
            din_s = {(state_q == ST_SERVICE), 11'b0, insvc_q};
        end else begin
            din_s = 16'h0000;
        end
    end

endmodule
